regfile_multiport_sb: RTL

- Parametrised register file: configurable data width, depth and read-port count; one write port.
- Adds a per-register pending-write scoreboard and a sequenced bulk-clear engine.
- Sits in the processor datapath between decode (reserve, read) and writeback (write).
- Register 0 is hardwired to zero.

---
 rtl/regfile_multiport_sb.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_multiport_sb.sv
// Multi-read-port register file with a per-register pending-write scoreboard and a sequenced bulk clear.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_multiport_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            pending_read,
  input  logic                           ctrl_reserve,
  input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
  input  logic                           ctrl_clear,
  output logic                           clear_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clearState_t;

  clearState_t             clearState;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]        pending;
  logic [ADDR_WIDTH-1:0]   clearPtr;
  logic                    isIdle;
  logic                    doWrite;
  logic                    doReserve;

  assign isIdle    = (clearState == IDLE);
  assign doWrite   = ctrl_writeEnable && (ctrl_writeReg != '0) && isIdle;
  assign doReserve = ctrl_reserve && (ctrl_reserveReg != '0) && isIdle;

  // Array, scoreboard and clear engine; a reserve on the same edge as a write overrides the write's pending clear.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
      pending    <= '0;
      clearState <= IDLE;
      clear_busy <= 1'b0;
      clearPtr   <= ADDR_WIDTH'(1);
    end else begin
      case (clearState)
        IDLE: begin
          if (doWrite) begin
            regs[ctrl_writeReg]    <= data_writeReg;
            pending[ctrl_writeReg] <= 1'b0;
          end
          if (doReserve) begin
            pending[ctrl_reserveReg] <= 1'b1;
          end
          if (ctrl_clear) begin
            pending    <= '0;
            clearPtr   <= ADDR_WIDTH'(1);
            clearState <= CLEAR;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          regs[clearPtr] <= '0;
          if (clearPtr == ADDR_WIDTH'(DEPTH - 1)) begin
            clearState <= IDLE;
            clear_busy <= 1'b0;
          end else begin
            clearPtr <= clearPtr + ADDR_WIDTH'(1);
          end
        end
        default: begin
          clearState <= IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read ports; index 0 and an asserted reset always read as zero, not pending.
  for (genvar k = 0; k < int'(NUM_READ); k++) begin : g_read
    logic [ADDR_WIDTH-1:0] rdIdx;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  rdPend;

    assign rdIdx = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rdData = regs[rdIdx];
      rdPend = pending[rdIdx];
`ifdef REGFILE_BYPASS_EN
      if (doWrite && (ctrl_writeReg == rdIdx)) begin
        rdData = data_writeReg;
        rdPend = doReserve && (ctrl_reserveReg == rdIdx);
      end
`endif
      if (ctrl_reset || (rdIdx == '0)) begin
        rdData = '0;
        rdPend = 1'b0;
      end
    end

    assign data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = rdData;
    assign pending_read[k]                          = rdPend;
  end

endmodule
